// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between a master/bridge and one apb_slave_regs completer.
// The completer drives only prdata/pready/pslverr; everything else comes from the master.
interface apb_slave_regs_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer with NUM_REGS RW registers plus one read-only status word at index NUM_REGS.
// Answers to paddr[10:8] == PORT_ID, inserts WAIT_CYCLES wait states, flags bad accesses on pslverr.
module apb_slave_regs #(
    parameter logic [2:0] PORT_ID     = 3'b010,
    parameter int         NUM_REGS    = 8,
    parameter int         WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    apb_slave_regs_if.slave          bus,
    input  logic [31:0]              hw_status,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic                     wr_pulse,
    output logic [5:0]               wr_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int         IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] STATUS_IDX = 6'(NUM_REGS);
    // One wait state is absorbed by the IDLE->WAIT edge, so the counter is preloaded with
    // WAIT_CYCLES-1; this gives WAIT_CYCLES+1 edges from the first penable cycle to pready.
    localparam logic [3:0] CNT_LOAD   = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [31:0]     regs [NUM_REGS];

    logic            hit;
    logic [5:0]      idx;
    logic [IW-1:0]   ridx;
    logic            complete;

    logic            pready_d;
    logic            pslverr_d;
    logic [31:0]     prdata_d;
    logic            wr_pulse_d;
    logic [5:0]      wr_idx_d;
    logic            wr_en;

    logic            unused_addr_bits;

    assign hit              = bus.psel && (bus.paddr[10:8] == PORT_ID);
    assign idx              = bus.paddr[7:2];
    assign ridx             = idx[IW-1:0];
    assign unused_addr_bits = ^{bus.paddr[11], bus.paddr[1:0]};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[32*i +: 32] = regs[i];
    end

    // State register plus all registered outputs and the register bank.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
            wr_pulse    <= 1'b0;
            wr_idx      <= '0;
            // NOTE: the register bank is architecturally visible after reset, so it is cleared here.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus.pready  <= pready_d;
            bus.pslverr <= pslverr_d;
            bus.prdata  <= prdata_d;
            wr_pulse    <= wr_pulse_d;
            wr_idx      <= wr_idx_d;
            if (wr_en) begin
                regs[ridx] <= bus.pwdata;
            end
        end
    end

    // Next-state and wait counter.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (hit && bus.penable) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    state_nxt = S_IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign complete = (state_nxt == S_RESP) && (state != S_RESP);

    // Output decode: responses are computed on the RESP-entry edge and cleared on the next one.
    always_comb begin
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx;
        wr_en      = 1'b0;
        if (complete) begin
            pready_d = 1'b1;
            if (idx < STATUS_IDX) begin
                if (bus.pwrite) begin
                    wr_en      = 1'b1;
                    wr_pulse_d = 1'b1;
                    wr_idx_d   = idx;
                end else begin
                    prdata_d = regs[ridx];
                end
            end else if (idx == STATUS_IDX) begin
                if (bus.pwrite) begin
                    pslverr_d = 1'b1;
                end else begin
                    prdata_d = hw_status;
                end
            end else begin
                pslverr_d = 1'b1;
            end
        end
    end

endmodule
